mio_mem_arbiter: RTL and testbench

//   Shares one single-port memory/peripheral bus between the multi-cycle CPU and a secondary
//   bus master (DMA/VGA refresh engine). Serialises requests and sequences each fixed-latency

---
 rtl/mio_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mio_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_mem_arbiter.sv
// mio_mem_arbiter: shares one single-port memory bus between the CPU and a
// secondary master (DMA/VGA). Each granted access holds mem_en for MEM_LAT
// cycles, then pulses the granted master's ready for one cycle.
// Every output is registered; requests only reach mem_* through a flop.
module mio_mem_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter bit PRIO_CPU = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        MIO_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic          G_CPU    = 1'b0;
  localparam logic          G_DMA    = 1'b1;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  // grant doubles as last_grant: it only changes when a new winner is picked
  logic          grant, grant_d;
  logic          en_d, we_d, crdy_d, drdy_d;
  logic [31:0]   addr_d, wdata_d, crd_d, drd_d;
  logic          pick_dma;

  // Next-state and next-output logic; every register holds unless told otherwise
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    grant_d   = grant;
    en_d      = mem_en;
    we_d      = mem_we;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    crd_d     = cpu_rdata;
    drd_d     = dma_rdata;
    crdy_d    = 1'b0;
    drdy_d    = 1'b0;
    // DMA wins if alone, or on a tie when round-robin says the CPU went last
    pick_dma  = dma_req && (!cpu_req || (!PRIO_CPU && grant == G_CPU));
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant_d = pick_dma;
          en_d    = 1'b1;
          we_d    = pick_dma ? dma_we    : cpu_we;
          addr_d  = pick_dma ? dma_addr  : cpu_addr;
          wdata_d = pick_dma ? dma_wdata : cpu_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          en_d = 1'b0;
          we_d = 1'b0;
          // mem_rdata is valid in this last strobe cycle; writes leave rdata alone
          if (!mem_we) begin
            if (grant == G_DMA) drd_d = mem_rdata;
            else                crd_d = mem_rdata;
          end
          crdy_d  = (grant == G_CPU);
          drdy_d  = (grant == G_DMA);
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      grant     <= G_DMA;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      MIO_ready <= 1'b0;
      dma_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      grant     <= grant_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      cpu_rdata <= crd_d;
      dma_rdata <= drd_d;
      MIO_ready <= crdy_d;
      dma_ready <= drdy_d;
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_mio_mem_arbiter.sv
// Bench for mio_mem_arbiter: three instances (MEM_LAT/PRIO_CPU = 2/0, 2/1, 1/0)
// share one stimulus; directed scenarios plus a random run against a
// transaction-schedule reference model.
module tb_mio_mem_arbiter;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

  logic        en_o[NI], we_o[NI], crdy_o[NI], drdy_o[NI];
  logic [31:0] addr_o[NI], wd_o[NI], crd_o[NI], drd_o[NI];
  logic [1:0]  st_o[NI];

  int lat[NI]  = '{2, 2, 1};
  bit prio[NI] = '{1'b0, 1'b1, 1'b0};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mio_mem_arbiter #(.MEM_LAT(2), .PRIO_CPU(1'b0)) u_rr2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(crd_o[0]), .MIO_ready(crdy_o[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(drd_o[0]), .dma_ready(drdy_o[0]),
    .mem_en(en_o[0]), .mem_we(we_o[0]), .mem_addr(addr_o[0]), .mem_wdata(wd_o[0]),
    .mem_rdata(mem_rdata), .arb_state(st_o[0]));

  mio_mem_arbiter #(.MEM_LAT(2), .PRIO_CPU(1'b1)) u_fp2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(crd_o[1]), .MIO_ready(crdy_o[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(drd_o[1]), .dma_ready(drdy_o[1]),
    .mem_en(en_o[1]), .mem_we(we_o[1]), .mem_addr(addr_o[1]), .mem_wdata(wd_o[1]),
    .mem_rdata(mem_rdata), .arb_state(st_o[1]));

  mio_mem_arbiter #(.MEM_LAT(1), .PRIO_CPU(1'b0)) u_rr1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(crd_o[2]), .MIO_ready(crdy_o[2]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(drd_o[2]), .dma_ready(drdy_o[2]),
    .mem_en(en_o[2]), .mem_we(we_o[2]), .mem_addr(addr_o[2]), .mem_wdata(wd_o[2]),
    .mem_rdata(mem_rdata), .arb_state(st_o[2]));

  // reference model: one pending transaction per instance, described by its grant cycle
  bit          m_has[NI];
  int          m_s[NI];
  bit          m_dma[NI];
  bit          m_we[NI];
  logic [31:0] m_addr[NI], m_wd[NI], m_crd[NI], m_drd[NI];
  int          m_nidle[NI];
  bit          m_last[NI];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drop_all();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic do_reset();
    drop_all();
    mem_rdata = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    cyc = 0;
  endtask

  task automatic test_reset();
    drop_all();
    mem_rdata = 32'hFFFF_FFFF;
    reset = 0;
    tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({en_o[i], we_o[i], crdy_o[i], drdy_o[i], st_o[i]} !== 6'b0) begin
        errors++;
        $display("FAIL reset ctrl inst%0d: got %b want 000000", i,
                 {en_o[i], we_o[i], crdy_o[i], drdy_o[i], st_o[i]});
      end
      checks++;
      if ({addr_o[i], wd_o[i], crd_o[i], drd_o[i]} !== 128'h0) begin
        errors++;
        $display("FAIL reset data inst%0d: got %h want 0", i,
                 {addr_o[i], wd_o[i], crd_o[i], drd_o[i]});
      end
    end
    reset = 1;
  endtask

  // CPU read of 0x10; instance 0 (MEM_LAT=2) and instance 2 (MEM_LAT=1)
  task automatic test_cpu_read();
    logic e_en, e_rdy, e_en2, e_rdy2;
    logic [1:0] e_st;
    do_reset();
    mem_rdata = 32'hDEAD_BEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      e_en   = (k == 1 || k == 2);
      e_rdy  = (k == 3);
      e_st   = (k <= 2) ? 2'd1 : (k == 3) ? 2'd2 : 2'd0;
      e_en2  = (k == 1);
      e_rdy2 = (k == 2);
      checks++;
      if (en_o[0] !== e_en) begin errors++; $display("FAIL cpu_read mem_en cyc%0d: got %b want %b", cyc, en_o[0], e_en); end
      checks++;
      if (crdy_o[0] !== e_rdy) begin errors++; $display("FAIL cpu_read MIO_ready cyc%0d: got %b want %b", cyc, crdy_o[0], e_rdy); end
      checks++;
      if (drdy_o[0] !== 1'b0) begin errors++; $display("FAIL cpu_read dma_ready cyc%0d: got %b want 0", cyc, drdy_o[0]); end
      checks++;
      if (st_o[0] !== e_st) begin errors++; $display("FAIL cpu_read arb_state cyc%0d: got %0d want %0d", cyc, st_o[0], e_st); end
      checks++;
      if (en_o[2] !== e_en2) begin errors++; $display("FAIL lat1 mem_en cyc%0d: got %b want %b", cyc, en_o[2], e_en2); end
      checks++;
      if (crdy_o[2] !== e_rdy2) begin errors++; $display("FAIL lat1 MIO_ready cyc%0d: got %b want %b", cyc, crdy_o[2], e_rdy2); end
      if (k == 1) begin
        checks++;
        if (addr_o[0] !== 32'h10 || we_o[0] !== 1'b0) begin
          errors++; $display("FAIL cpu_read addr/we: got %h/%b want 00000010/0", addr_o[0], we_o[0]);
        end
      end
      if (k == 2) begin
        checks++;
        if (crd_o[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat1 cpu_rdata: got %h want deadbeef", crd_o[2]); end
      end
      if (k == 3) begin
        checks++;
        if (crd_o[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_read cpu_rdata: got %h want deadbeef", crd_o[0]); end
        cpu_req = 0;
      end
    end
  endtask

  // DMA read (to load dma_rdata) then DMA write to 0x40; write leaves dma_rdata alone
  task automatic test_dma_write();
    logic e_wen, e_rdy;
    do_reset();
    mem_rdata = 32'hA5A5_0001;
    dma_req = 1; dma_we = 0; dma_addr = 32'h80;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_wen = (k == 5 || k == 6);
      e_rdy = (k == 3 || k == 7);
      checks++;
      if (drdy_o[0] !== e_rdy) begin errors++; $display("FAIL dma dma_ready cyc%0d: got %b want %b", cyc, drdy_o[0], e_rdy); end
      checks++;
      if (crdy_o[0] !== 1'b0) begin errors++; $display("FAIL dma MIO_ready cyc%0d: got %b want 0", cyc, crdy_o[0]); end
      if (k >= 4) begin
        checks++;
        if (en_o[0] !== e_wen || we_o[0] !== e_wen) begin
          errors++; $display("FAIL dma_write en/we cyc%0d: got %b%b want %b%b", cyc, en_o[0], we_o[0], e_wen, e_wen);
        end
      end
      if (e_wen) begin
        checks++;
        if (addr_o[0] !== 32'h40 || wd_o[0] !== 32'h1234_5678) begin
          errors++; $display("FAIL dma_write addr/data cyc%0d: got %h/%h want 00000040/12345678", cyc, addr_o[0], wd_o[0]);
        end
      end
      if (k == 3 || k == 7) begin
        checks++;
        if (drd_o[0] !== 32'hA5A5_0001) begin errors++; $display("FAIL dma dma_rdata cyc%0d: got %h want a5a50001", cyc, drd_o[0]); end
      end
      if (k == 3) begin
        dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h1234_5678; mem_rdata = 32'h0BAD_F00D;
      end
      if (k == 7) dma_req = 0;
    end
  endtask

  // both request at cycle 0: CPU first, DMA granted in cycle 4
  task automatic test_tie();
    logic e_en, e_c, e_d;
    do_reset();
    cpu_req = 1; cpu_addr = 32'h100;
    dma_req = 1; dma_addr = 32'h200;
    mem_rdata = 32'h5555_AAAA;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_en = (k == 1 || k == 2 || k == 5 || k == 6);
      e_c  = (k == 3);
      e_d  = (k == 7);
      checks++;
      if ({en_o[0], crdy_o[0], drdy_o[0]} !== {e_en, e_c, e_d}) begin
        errors++; $display("FAIL tie en/cpu/dma cyc%0d: got %b want %b", cyc,
                           {en_o[0], crdy_o[0], drdy_o[0]}, {e_en, e_c, e_d});
      end
      if (k == 1 || k == 5) begin
        checks++;
        if (addr_o[0] !== ((k == 1) ? 32'h100 : 32'h200)) begin
          errors++; $display("FAIL tie mem_addr cyc%0d: got %h", cyc, addr_o[0]);
        end
      end
      if (k == 3) cpu_req = 0;
      if (k == 7) dma_req = 0;
    end
  endtask

  // both held for four transactions: C,D,C,D round-robin vs C,C,C,C fixed priority
  task automatic test_back_to_back();
    logic e_c0, e_d0, e_c1;
    do_reset();
    cpu_req = 1; dma_req = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e_c0 = (k == 3 || k == 11);
      e_d0 = (k == 7 || k == 15);
      e_c1 = (k % 4 == 3);
      checks++;
      if ({crdy_o[0], drdy_o[0]} !== {e_c0, e_d0}) begin
        errors++; $display("FAIL b2b rr ready cyc%0d: got %b want %b", cyc, {crdy_o[0], drdy_o[0]}, {e_c0, e_d0});
      end
      checks++;
      if ({crdy_o[1], drdy_o[1]} !== {e_c1, 1'b0}) begin
        errors++; $display("FAIL b2b prio ready cyc%0d: got %b want %b", cyc, {crdy_o[1], drdy_o[1]}, {e_c1, 1'b0});
      end
    end
    drop_all();
  endtask

  // reset in first ACCESS cycle aborts at once; held req restarts from scratch
  task automatic test_reset_mid();
    logic e_en, e_rdy;
    do_reset();
    cpu_req = 1; cpu_addr = 32'h10; mem_rdata = 32'h1111_2222;
    tick();
    checks++;
    if (en_o[0] !== 1'b1) begin errors++; $display("FAIL rst_mid precondition mem_en: got %b want 1", en_o[0]); end
    reset = 0;
    #1;
    checks++;
    if ({en_o[0], we_o[0], crdy_o[0], st_o[0]} !== 5'b0) begin
      errors++; $display("FAIL rst_mid abort: got %b want 00000", {en_o[0], we_o[0], crdy_o[0], st_o[0]});
    end
    tick();
    checks++;
    if (crdy_o[0] !== 1'b0) begin errors++; $display("FAIL rst_mid MIO_ready in reset: got %b want 0", crdy_o[0]); end
    reset = 1;
    cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      e_en  = (k == 1 || k == 2);
      e_rdy = (k == 3);
      checks++;
      if ({en_o[0], crdy_o[0]} !== {e_en, e_rdy}) begin
        errors++; $display("FAIL rst_mid restart cyc%0d: got %b want %b", cyc, {en_o[0], crdy_o[0]}, {e_en, e_rdy});
      end
      if (k == 3) begin
        checks++;
        if (crd_o[0] !== 32'h1111_2222) begin errors++; $display("FAIL rst_mid cpu_rdata: got %h want 11112222", crd_o[0]); end
        cpu_req = 0;
      end
    end
  endtask

  // random traffic, resets and mid-transaction input changes against the model
  task automatic test_random();
    logic        e_en, e_we, e_c, e_d, pd;
    logic [1:0]  e_st;
    do_reset();
    for (int i = 0; i < NI; i++) begin
      m_has[i] = 0; m_nidle[i] = 0; m_last[i] = 1; m_crd[i] = 0; m_drd[i] = 0;
    end
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 0;
        #1;
        for (int i = 0; i < NI; i++) begin
          checks++;
          if ({en_o[i], we_o[i], crdy_o[i], drdy_o[i], st_o[i]} !== 6'b0) begin
            errors++; $display("FAIL rand async reset inst%0d cyc%0d: got %b want 0", i, cyc,
                               {en_o[i], we_o[i], crdy_o[i], drdy_o[i], st_o[i]});
          end
          m_has[i] = 0; m_nidle[i] = cyc + 1; m_last[i] = 1; m_crd[i] = 0; m_drd[i] = 0;
        end
        tick();
        reset = 1;
      end else begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom);
        cpu_addr = $urandom; cpu_wdata = $urandom;
        dma_req = ($urandom_range(0, 3) != 0); dma_we = 1'($urandom);
        dma_addr = $urandom; dma_wdata = $urandom;
        mem_rdata = $urandom;
        for (int i = 0; i < NI; i++) begin
          if (m_has[i] && cyc == m_s[i] + lat[i] && !m_we[i]) begin
            if (m_dma[i]) m_drd[i] = mem_rdata;
            else          m_crd[i] = mem_rdata;
          end
          if (cyc >= m_nidle[i] && (cpu_req || dma_req)) begin
            if (cpu_req && dma_req) pd = prio[i] ? 1'b0 : !m_last[i];
            else                    pd = dma_req;
            m_has[i]  = 1;
            m_s[i]    = cyc;
            m_dma[i]  = pd;
            m_last[i] = pd;
            m_we[i]   = pd ? dma_we : cpu_we;
            m_addr[i] = pd ? dma_addr : cpu_addr;
            m_wd[i]   = pd ? dma_wdata : cpu_wdata;
            m_nidle[i] = cyc + lat[i] + 2;
          end
        end
        tick();
      end
      for (int i = 0; i < NI; i++) begin
        e_en = m_has[i] && cyc <= m_s[i] + lat[i];
        e_we = e_en && m_we[i];
        e_c  = m_has[i] && cyc == m_s[i] + lat[i] + 1 && !m_dma[i];
        e_d  = m_has[i] && cyc == m_s[i] + lat[i] + 1 && m_dma[i];
        e_st = (!m_has[i] || cyc >= m_nidle[i]) ? 2'd0 : (cyc <= m_s[i] + lat[i]) ? 2'd1 : 2'd2;
        checks++;
        if ({en_o[i], we_o[i], crdy_o[i], drdy_o[i], st_o[i]} !== {e_en, e_we, e_c, e_d, e_st}) begin
          errors++; $display("FAIL rand ctrl inst%0d cyc%0d: got %b want %b", i, cyc,
                             {en_o[i], we_o[i], crdy_o[i], drdy_o[i], st_o[i]}, {e_en, e_we, e_c, e_d, e_st});
        end
        checks++;
        if (crd_o[i] !== m_crd[i] || drd_o[i] !== m_drd[i]) begin
          errors++; $display("FAIL rand rdata inst%0d cyc%0d: got %h/%h want %h/%h", i, cyc,
                             crd_o[i], drd_o[i], m_crd[i], m_drd[i]);
        end
        if (e_en) begin
          checks++;
          if (addr_o[i] !== m_addr[i] || wd_o[i] !== m_wd[i]) begin
            errors++; $display("FAIL rand addr/wdata inst%0d cyc%0d: got %h/%h want %h/%h", i, cyc,
                               addr_o[i], wd_o[i], m_addr[i], m_wd[i]);
          end
        end
      end
    end
    drop_all();
  endtask

  initial begin
    drop_all();
    mem_rdata = 0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // guard against a stalled run
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
